fifo_ctrl: RTL and testbench

Pointer and flag controller for the register-based FIFO. It takes a push/pop request stream and drives the per-entry `push` strobes and the shared `enable` (full) input of the `DEPTH` 16-bit storage register stages. It reads their concatenated outputs back and presents the popped word on a registered output. It sits directly upstream of the storage registers on the write side and directly downstream of them on the read side.

---
 rtl/fifo_ctrl_if.sv | 29 ++
 rtl/fifo_ctrl.sv | 100 ++++++++++
 tb/tb_fifo_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_ctrl_if.sv
// Request/response and storage-stage signals between a FIFO user, the
// register stages and the fifo_ctrl pointer/flag controller.
interface fifo_ctrl_if #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  parameter int AW    = 3
);
  logic                     push;
  logic                     pop;
  logic [DEPTH*WIDTH-1:0]   reg_bus;
  logic [DEPTH-1:0]         wr_push;
  logic                     full;
  logic                     empty;
  logic [AW:0]              count;
  logic [WIDTH-1:0]         data_out;
  logic                     data_valid;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output push, pop, reg_bus,
    input  wr_push, full, empty, count, data_out, data_valid, overflow, underflow
  );

  modport slave (
    input  push, pop, reg_bus,
    output wr_push, full, empty, count, data_out, data_valid, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/count controller for a register-based FIFO: steers push strobes to
// the storage stages and registers the popped word from their outputs.
module fifo_ctrl #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input logic       clk,
  input logic       rst,
  fifo_ctrl_if.slave bus
);

  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             full, empty;
  logic             wr_acc, rd_acc;
  logic [WIDTH-1:0] rd_word;
  logic [DEPTH-1:0] wr_push;

  // Flags come from the count register alone, never from the requests.
  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  assign wr_acc  = bus.push && !full;
  assign rd_acc  = bus.pop && !empty;
  assign rd_word = bus.reg_bus[rd_ptr_q*WIDTH +: WIDTH];

  // Strobe is left ungated by full; each stage ignores push while enable is high.
  always_comb begin
    wr_push = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wr_push[i] = bus.push && (wr_ptr_q == AW'(i));
    end
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    overflow_d   = bus.push && full;
    underflow_d  = bus.pop && empty;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (rd_acc) begin
      rd_ptr_d     = rd_ptr_q + PTR_ONE;
      data_out_d   = rd_word;
      data_valid_d = 1'b1;
    end

    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  assign bus.wr_push    = wr_push;
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.count      = count_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.overflow   = overflow_q;
  assign bus.underflow  = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl with a behavioural model of the eight
// 16-bit storage stages wired to wr_push/full/reg_bus.
module tb_fifo_ctrl;
  localparam int DEPTH = 8;
  localparam int WIDTH = 16;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] wdata = '0;
  logic [WIDTH-1:0] stage [DEPTH];
  logic [DEPTH*WIDTH-1:0] reg_bus_v;
  int               errors = 0;
  int               checks = 0;

  fifo_ctrl_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) bus ();

  fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Storage stages: capture data_in on push unless enable (full) is high.
  always @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.wr_push[i] && !bus.full) stage[i] <= wdata;
    end
  end

  always_comb begin
    reg_bus_v = '0;
    for (int i = 0; i < DEPTH; i++) reg_bus_v[i*WIDTH +: WIDTH] = stage[i];
  end
  assign bus.reg_bus = reg_bus_v;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic p, input logic q, input logic [WIDTH-1:0] d);
    bus.push = p;
    bus.pop  = q;
    wdata    = d;
    #1;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  initial begin
    bus.push = 1'b0;
    bus.pop  = 1'b0;

    // Reset values while held in reset
    #3;
    checkOutput("rst_count", 32'(bus.count), 32'd0);
    checkOutput("rst_empty", 32'(bus.empty), 32'd1);
    checkOutput("rst_full", 32'(bus.full), 32'd0);
    checkOutput("rst_dvalid", 32'(bus.data_valid), 32'd0);
    checkOutput("rst_dout", 32'(bus.data_out), 32'd0);
    checkOutput("rst_wrpush", 32'(bus.wr_push), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    stepClock();

    // Fill with 0x0001..0x0008
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 1'b0, 16'(i + 1));
      checkOutput("fill_wrpush", 32'(bus.wr_push), 32'(1) << i);
      stepClock();
      checkOutput("fill_count", 32'(bus.count), 32'(i + 1));
      checkOutput("fill_empty", 32'(bus.empty), 32'd0);
      checkOutput("fill_full", 32'(bus.full), (i == DEPTH - 1) ? 32'd1 : 32'd0);
    end

    // Overflow: push while full, no pop
    applyStimulus(1'b1, 1'b0, 16'hBEEF);
    checkOutput("ovf_wrpush", 32'(bus.wr_push), 32'h01);
    stepClock();
    checkOutput("ovf_pulse", 32'(bus.overflow), 32'd1);
    checkOutput("ovf_count", 32'(bus.count), 32'd8);
    checkOutput("ovf_dvalid", 32'(bus.data_valid), 32'd0);
    stepClock();
    checkOutput("ovf_pulse_end", 32'(bus.overflow), 32'd0);

    // Drain: eight pops in order, one per cycle, no 0xBEEF
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, 1'b1, 16'h0);
      stepClock();
      checkOutput("drain_dout", 32'(bus.data_out), 32'(i + 1));
      checkOutput("drain_dvalid", 32'(bus.data_valid), 32'd1);
      checkOutput("drain_count", 32'(bus.count), 32'(DEPTH - 1 - i));
    end
    checkOutput("drain_empty", 32'(bus.empty), 32'd1);

    // Underflow: pop alone when empty
    applyStimulus(1'b0, 1'b1, 16'h0);
    stepClock();
    checkOutput("udf_pulse", 32'(bus.underflow), 32'd1);
    checkOutput("udf_dvalid", 32'(bus.data_valid), 32'd0);
    checkOutput("udf_dout_hold", 32'(bus.data_out), 32'h0008);
    stepClock();
    checkOutput("udf_pulse_end", 32'(bus.underflow), 32'd0);

    // Push and pop together when empty
    applyStimulus(1'b1, 1'b1, 16'h1234);
    stepClock();
    checkOutput("epp_count", 32'(bus.count), 32'd1);
    checkOutput("epp_underflow", 32'(bus.underflow), 32'd1);
    checkOutput("epp_dvalid", 32'(bus.data_valid), 32'd0);
    applyStimulus(1'b0, 1'b1, 16'h0);
    stepClock();
    checkOutput("epp_dout", 32'(bus.data_out), 32'h1234);
    checkOutput("epp_dvalid2", 32'(bus.data_valid), 32'd1);
    checkOutput("epp_count2", 32'(bus.count), 32'd0);

    // Pointer wrap: wr_ptr=1, rd_ptr=1; load 7 words to reach count 7
    for (int k = 0; k < 7; k++) begin
      applyStimulus(1'b1, 1'b0, 16'(16'h0100 + k));
      stepClock();
    end
    checkOutput("wrap_count_pre", 32'(bus.count), 32'd7);
    for (int j = 0; j < 10; j++) begin
      applyStimulus(1'b1, 1'b1, 16'(16'h0200 + j));
      checkOutput("wrap_wrpush", 32'(bus.wr_push), 32'(1) << (j % DEPTH));
      stepClock();
      checkOutput("wrap_dout", 32'(bus.data_out), (j < 7) ? 32'(16'h0100 + j) : 32'(16'h0200 + j - 7));
      checkOutput("wrap_count", 32'(bus.count), 32'd7);
    end

    // Reach full, then push and pop together
    applyStimulus(1'b1, 1'b0, 16'h0300);
    stepClock();
    checkOutput("fpp_full_pre", 32'(bus.full), 32'd1);
    applyStimulus(1'b1, 1'b1, 16'h0400);
    checkOutput("fpp_wrpush", 32'(bus.wr_push), 32'h08);
    stepClock();
    checkOutput("fpp_dout", 32'(bus.data_out), 32'h0203);
    checkOutput("fpp_count", 32'(bus.count), 32'd7);
    checkOutput("fpp_overflow", 32'(bus.overflow), 32'd1);

    // Pop twice to count 5, then reset mid-stream
    applyStimulus(1'b0, 1'b1, 16'h0);
    stepClock();
    applyStimulus(1'b0, 1'b1, 16'h0);
    stepClock();
    checkOutput("mid_dout_pre", 32'(bus.data_out), 32'h0205);
    checkOutput("mid_count_pre", 32'(bus.count), 32'd5);
    rst = 1'b0;
    #1;
    checkOutput("mid_count", 32'(bus.count), 32'd0);
    checkOutput("mid_empty", 32'(bus.empty), 32'd1);
    checkOutput("mid_full", 32'(bus.full), 32'd0);
    checkOutput("mid_dout", 32'(bus.data_out), 32'd0);
    checkOutput("mid_dvalid", 32'(bus.data_valid), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    stepClock();
    checkOutput("post_count", 32'(bus.count), 32'd0);
    checkOutput("post_empty", 32'(bus.empty), 32'd1);
    checkOutput("post_wrpush", 32'(bus.wr_push), 32'd0);

    // Pointers restart at stage 0 after reset
    applyStimulus(1'b1, 1'b0, 16'h5555);
    checkOutput("post_wrpush0", 32'(bus.wr_push), 32'h01);
    stepClock();
    applyStimulus(1'b0, 1'b1, 16'h0);
    stepClock();
    checkOutput("post_dout", 32'(bus.data_out), 32'h5555);
    checkOutput("post_dvalid", 32'(bus.data_valid), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
